// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX stream arbiter.
// UART_ARB_HDR_EN (optional macro) enables the per-packet header state.
package uart_tx_arbiter_pkg;

  localparam int UART_DATA_WIDTH  = 8;
  localparam int UART_ARB_MAX_REQ = 16;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_HDR  = 2'd1;
  localparam arb_state_t ARB_DATA = 2'd2;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any_req
);

  always_comb begin
    int k;
    k       = 0;
    pick    = '0;
    idx     = '0;
    any_req = |req;
    // Walk from the farthest offset to the nearest so the nearest winner overwrites.
    for (int i = N; i >= 1; i--) begin
      k = (int'(last_grant) + i) % N;
      if (req[k]) begin
        pick    = '0;
        pick[k] = 1'b1;
        idx     = IW'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the single UART TX byte stream.
// Define UART_ARB_HDR_EN to prefix every grant with a requester-index header byte.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = UART_DATA_WIDTH,
  parameter int MAX_PKT_LEN = 256
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic [NUM_REQ-1:0]                  s_tvalid_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  s_tdata_i,
  input  logic [NUM_REQ-1:0]                  s_tlast_i,
  output logic [NUM_REQ-1:0]                  s_tready_o,
  output logic                                m_tvalid_o,
  output logic [DATA_WIDTH-1:0]               m_tdata_o,
  output logic                                m_tlast_o,
  input  logic                                m_tready_i,
  output logic [NUM_REQ-1:0]                  grant_o,
  output logic                                busy_o,
  output logic                                pkt_split_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_PKT_LEN);

  arb_state_t           state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IW-1:0]        gidx_q;
  logic [IW-1:0]        last_q;
  logic [CW-1:0]        cnt_q;

  logic [NUM_REQ-1:0]   pick;
  logic [IW-1:0]        pick_idx;
  logic                 any_req;
  logic                 sel_vld;
  logic                 sel_last;
  logic                 at_limit;
  logic                 xfer;
  logic                 pkt_end;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req        (s_tvalid_i),
    .last_grant (last_q),
    .pick       (pick),
    .idx        (pick_idx),
    .any_req    (any_req)
  );

  assign sel_vld  = s_tvalid_i[gidx_q];
  assign sel_last = s_tlast_i[gidx_q];
  assign at_limit = (cnt_q == CW'(MAX_PKT_LEN - 1));
  assign xfer     = (state_q == ARB_DATA) && sel_vld && m_tready_i;
  assign pkt_end  = xfer && (sel_last || at_limit);

  assign grant_o  = grant_q;
  assign busy_o   = (state_q != ARB_IDLE);

  always_comb begin
    m_tvalid_o  = 1'b0;
    m_tdata_o   = '0;
    m_tlast_o   = 1'b0;
    s_tready_o  = '0;
    pkt_split_o = 1'b0;
    case (state_q)
      ARB_DATA: begin
        m_tvalid_o         = sel_vld;
        m_tdata_o          = s_tdata_i[gidx_q];
        m_tlast_o          = sel_vld && (sel_last || at_limit);
        s_tready_o[gidx_q] = m_tready_i;
        // Guard fires only when the producer did not end the packet itself.
        pkt_split_o        = xfer && at_limit && !sel_last;
      end
`ifdef UART_ARB_HDR_EN
      ARB_HDR: begin
        m_tvalid_o = 1'b1;
        m_tdata_o  = DATA_WIDTH'(gidx_q);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (any_req) begin
            grant_q <= pick;
            gidx_q  <= pick_idx;
`ifdef UART_ARB_HDR_EN
            state_q <= ARB_HDR;
`else
            state_q <= ARB_DATA;
`endif
          end
        end
`ifdef UART_ARB_HDR_EN
        ARB_HDR: begin
          if (m_tready_i) state_q <= ARB_DATA;
        end
`endif
        ARB_DATA: begin
          if (pkt_end) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= gidx_q;
            cnt_q   <= '0;
          end else if (xfer) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter (4 requesters, 4-byte length guard).
module tb_uart_tx_arbiter;

  logic             clk = 1'b0;
  logic             rstn;
  logic [3:0]       s_tvalid;
  logic [3:0][7:0]  s_tdata;
  logic [3:0]       s_tlast;
  logic [3:0]       s_tready;
  logic             m_tvalid;
  logic [7:0]       m_tdata;
  logic             m_tlast;
  logic             m_tready;
  logic [3:0]       grant;
  logic             busy;
  logic             pkt_split;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_PKT_LEN(4)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .s_tvalid_i  (s_tvalid),
    .s_tdata_i   (s_tdata),
    .s_tlast_i   (s_tlast),
    .s_tready_o  (s_tready),
    .m_tvalid_o  (m_tvalid),
    .m_tdata_o   (m_tdata),
    .m_tlast_o   (m_tlast),
    .m_tready_i  (m_tready),
    .grant_o     (grant),
    .busy_o      (busy),
    .pkt_split_o (pkt_split)
  );

  typedef struct {
    logic        rs;
    logic [3:0]  vl;
    logic [31:0] dt;
    logic [3:0]  ls;
    logic        rd;
    logic [3:0]  eg;
    logic        emv;
    logic [7:0]  emd;
    logic        eml;
    logic [3:0]  esr;
    logic        esp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] d(input int i, input logic [7:0] b);
    return 32'(b) << (8 * i);
  endfunction

  task automatic add(input logic rs, input logic [3:0] vl, input logic [31:0] dt,
                     input logic [3:0] ls, input logic rd, input logic [3:0] eg,
                     input logic emv, input logic [7:0] emd, input logic eml,
                     input logic [3:0] esr, input logic esp);
    vec_t t;
    t.rs = rs; t.vl = vl; t.dt = dt; t.ls = ls; t.rd = rd;
    t.eg = eg; t.emv = emv; t.emd = emd; t.eml = eml; t.esr = esr; t.esp = esp;
    tbl.push_back(t);
  endtask

  task automatic idle_row();
    add(1'b1, 4'b0, 32'h0, 4'b0, 1'b1, 4'b0, 1'b0, 8'h0, 1'b0, 4'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic [3:0] vl, input logic [31:0] dt,
                       input logic [3:0] ls, input logic rd);
    @(negedge clk);
    rstn = rs; s_tvalid = vl; s_tdata = dt; s_tlast = ls; m_tready = rd;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eg, input logic emv,
                         input logic [7:0] emd, input logic eml, input logic [3:0] esr,
                         input logic esp);
    chk({tag, " grant"}, 32'(grant), 32'(eg));
    chk({tag, " busy"}, 32'(busy), 32'(|eg));
    chk({tag, " m_tvalid"}, 32'(m_tvalid), 32'(emv));
    if (emv) chk({tag, " m_tdata"}, 32'(m_tdata), 32'(emd));
    chk({tag, " m_tlast"}, 32'(m_tlast), 32'(eml));
    chk({tag, " s_tready"}, 32'(s_tready), 32'(esr));
    chk({tag, " pkt_split"}, 32'(pkt_split), 32'(esp));
  endtask

  // Header byte precedes data only when the header feature is built in.
  task automatic hdr_step(input string tag, input logic [3:0] eg, input logic [7:0] idx);
`ifdef UART_ARB_HDR_EN
    chk_out(tag, eg, 1'b1, idx, 1'b0, 4'b0, 1'b0);
    @(negedge clk);
    #1;
`else
    if (idx === 8'hxx) chk({tag, " hdr idx"}, 32'(idx), 32'h0);
`endif
  endtask

  initial begin
    rstn = 1'b0; s_tvalid = '0; s_tdata = '0; s_tlast = '0; m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_out("reset", 4'b0, 1'b0, 8'h0, 1'b0, 4'b0, 1'b0);

`ifndef UART_ARB_HDR_EN
    // Single requester 2, three bytes.
    add(1, 4'b0100, d(2, 8'h41), 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 4'b0000, 0);
    add(1, 4'b0100, d(2, 8'h41), 4'b0000, 1, 4'b0100, 1, 8'h41, 0, 4'b0100, 0);
    add(1, 4'b0100, d(2, 8'h42), 4'b0000, 1, 4'b0100, 1, 8'h42, 0, 4'b0100, 0);
    add(1, 4'b0100, d(2, 8'h43), 4'b0100, 1, 4'b0100, 1, 8'h43, 1, 4'b0100, 0);
    idle_row();
    add(0, 4'b0000, 32'h0, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 4'b0000, 0);
    // All four requesting 1-byte packets: 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      add(1, 4'hF, 32'h13121110, 4'hF, 1, 4'b0000, 0, 8'h00, 0, 4'b0000, 0);
      add(1, 4'hF, 32'h13121110, 4'hF, 1, 4'(1 << (k % 4)), 1, 8'(8'h10 + k % 4), 1,
          4'(1 << (k % 4)), 0);
    end
    idle_row();
    // Requester 1 re-requests while 3 waits: 3 goes first.
    add(1, 4'b0010, d(1, 8'h21), 4'b0010, 1, 4'b0000, 0, 8'h00, 0, 4'b0000, 0);
    add(1, 4'b1010, d(1, 8'h21) | d(3, 8'h33), 4'b1010, 1, 4'b0010, 1, 8'h21, 1, 4'b0010, 0);
    add(1, 4'b1010, d(1, 8'h22) | d(3, 8'h33), 4'b1010, 1, 4'b0000, 0, 8'h00, 0, 4'b0000, 0);
    add(1, 4'b1010, d(1, 8'h22) | d(3, 8'h33), 4'b1010, 1, 4'b1000, 1, 8'h33, 1, 4'b1000, 0);
    add(1, 4'b0010, d(1, 8'h22), 4'b0010, 1, 4'b0000, 0, 8'h00, 0, 4'b0000, 0);
    add(1, 4'b0010, d(1, 8'h22), 4'b0010, 1, 4'b0010, 1, 8'h22, 1, 4'b0010, 0);
    idle_row();
    // Backpressure and a valid drop during a 4-byte packet; tlast on the limit byte.
    add(1, 4'b0001, d(0, 8'h50), 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 4'b0000, 0);
    add(1, 4'b0001, d(0, 8'h50), 4'b0000, 1, 4'b0001, 1, 8'h50, 0, 4'b0001, 0);
    add(1, 4'b0000, d(0, 8'h51), 4'b0000, 1, 4'b0001, 0, 8'h00, 0, 4'b0001, 0);
    add(1, 4'b0001, d(0, 8'h51), 4'b0000, 0, 4'b0001, 1, 8'h51, 0, 4'b0000, 0);
    add(1, 4'b0001, d(0, 8'h51), 4'b0000, 0, 4'b0001, 1, 8'h51, 0, 4'b0000, 0);
    add(1, 4'b0001, d(0, 8'h51), 4'b0000, 1, 4'b0001, 1, 8'h51, 0, 4'b0001, 0);
    add(1, 4'b0001, d(0, 8'h52), 4'b0000, 1, 4'b0001, 1, 8'h52, 0, 4'b0001, 0);
    add(1, 4'b0001, d(0, 8'h53), 4'b0001, 1, 4'b0001, 1, 8'h53, 1, 4'b0001, 0);
    idle_row();
    // 6-byte packet split by the 4-byte guard, remainder regranted.
    add(1, 4'b0001, d(0, 8'h60), 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 4'b0000, 0);
    add(1, 4'b0001, d(0, 8'h60), 4'b0000, 1, 4'b0001, 1, 8'h60, 0, 4'b0001, 0);
    add(1, 4'b0001, d(0, 8'h61), 4'b0000, 1, 4'b0001, 1, 8'h61, 0, 4'b0001, 0);
    add(1, 4'b0001, d(0, 8'h62), 4'b0000, 1, 4'b0001, 1, 8'h62, 0, 4'b0001, 0);
    add(1, 4'b0001, d(0, 8'h63), 4'b0000, 1, 4'b0001, 1, 8'h63, 1, 4'b0001, 1);
    add(1, 4'b0001, d(0, 8'h64), 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 4'b0000, 0);
    add(1, 4'b0001, d(0, 8'h64), 4'b0000, 1, 4'b0001, 1, 8'h64, 0, 4'b0001, 0);
    add(1, 4'b0001, d(0, 8'h65), 4'b0001, 1, 4'b0001, 1, 8'h65, 1, 4'b0001, 0);
    idle_row();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rs, tbl[i].vl, tbl[i].dt, tbl[i].ls, tbl[i].rd);
      chk_out($sformatf("v%0d", i), tbl[i].eg, tbl[i].emv, tbl[i].emd, tbl[i].eml,
              tbl[i].esr, tbl[i].esp);
    end
`endif

    // Reset in the middle of a 5-byte packet from requester 1.
    drive(1, 4'b0010, d(1, 8'h70), 4'b0000, 1);
    chk_out("mr idle", 4'b0000, 0, 8'h00, 0, 4'b0000, 0);
    @(negedge clk);
    #1;
    hdr_step("mr hdr1", 4'b0010, 8'h01);
    chk_out("mr b1", 4'b0010, 1, 8'h70, 0, 4'b0010, 0);
    drive(1, 4'b0010, d(1, 8'h71), 4'b0000, 1);
    chk_out("mr b2", 4'b0010, 1, 8'h71, 0, 4'b0010, 0);
    drive(0, 4'b0010, d(1, 8'h72), 4'b0000, 1);
    drive(1, 4'b0000, 32'h0, 4'b0000, 1);
    chk_out("mr post", 4'b0000, 0, 8'h00, 0, 4'b0000, 0);
    drive(1, 4'b1000, d(3, 8'h80), 4'b1000, 1);
    chk_out("r3 idle", 4'b0000, 0, 8'h00, 0, 4'b0000, 0);
    @(negedge clk);
    #1;
    hdr_step("r3 hdr", 4'b1000, 8'h03);
    chk_out("r3 b1", 4'b1000, 1, 8'h80, 1, 4'b1000, 0);
    drive(1, 4'b0000, 32'h0, 4'b0000, 1);
    chk_out("r3 done", 4'b0000, 0, 8'h00, 0, 4'b0000, 0);
    // Priority after reset: with 0 and 3 both waiting, 0 wins.
    drive(1, 4'b1001, d(0, 8'h90) | d(3, 8'h93), 4'b1001, 1);
    @(negedge clk);
    #1;
    chk("prio grant", 32'(grant), 32'(4'b0001));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
